// File: rtl/word_unpacker_if.sv
// Handshake bundle between a packed-word source, a field consumer and the word_unpacker.
// The master side drives words, requests and flush; the slave side returns readiness, fields and the bit count.
interface word_unpacker_if #(
  parameter int WIDTH   = 128,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = $clog2(2 * WIDTH + 1)
);
  logic               i_word_valid;
  logic               o_word_ready;
  logic [WIDTH-1:0]   i_word;
  logic               i_req_valid;
  logic [LEN_W-1:0]   i_req_len;
  logic               o_req_ready;
  logic               o_field_valid;
  logic [MAX_LEN-1:0] o_field;
  logic [CNT_W-1:0]   o_count;
  logic               i_flush;

  modport master (
    output i_word_valid, i_word, i_req_valid, i_req_len, i_flush,
    input  o_word_ready, o_req_ready, o_field_valid, o_field, o_count
  );

  modport slave (
    input  i_word_valid, i_word, i_req_valid, i_req_len, i_flush,
    output o_word_ready, o_req_ready, o_field_valid, o_field, o_count
  );
endinterface

// File: rtl/word_unpacker.sv
// Bit-stream unpacker: buffers packed WIDTH-bit words in a 2*WIDTH MSB-aligned window
// and hands out MSB-first fields of 0..MAX_LEN bits, straddling word boundaries transparently.
module word_unpacker #(
  parameter int WIDTH   = 128,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = $clog2(2 * WIDTH + 1)
) (
  input logic            i_clk,
  input logic            i_reset,
  word_unpacker_if.slave bus
);
  localparam int BUF_W = 2 * WIDTH;
  localparam int EXT_W = CNT_W + 1;

  logic [BUF_W-1:0]   buf_reg;
  logic [BUF_W-1:0]   buf_next;
  logic [BUF_W-1:0]   shifted;
  logic [BUF_W-1:0]   keep_mask;
  logic [BUF_W-1:0]   word_ext;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;
  logic [CNT_W-1:0]   count_after;
  logic [MAX_LEN-1:0] field_reg;
  logic [MAX_LEN-1:0] field_next;
  logic               field_valid_reg;
  logic [LEN_W-1:0]   len;
  logic               word_ready;
  logic               req_ready;
  logic               served;
  logic               accepted;

  assign len = (bus.i_req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.i_req_len;

  // Readiness looks only at the registered count, so a word arriving this cycle cannot serve a request this cycle.
  assign word_ready = !i_reset && !bus.i_flush && (count_reg <= CNT_W'(WIDTH));
  assign req_ready  = !i_reset && !bus.i_flush && (count_reg >= CNT_W'(len));
  assign served     = bus.i_req_valid && req_ready;
  assign accepted   = bus.i_word_valid && word_ready;

  assign shifted     = served ? (buf_reg << len) : buf_reg;
  assign count_after = served ? (count_reg - CNT_W'(len)) : count_reg;

  // The new word lands directly behind the bits that survive this cycle's consume.
  assign word_ext = {bus.i_word, {WIDTH{1'b0}}} >> count_after;

  generate
    for (genvar gi = 0; gi < BUF_W; gi++) begin : g_keep
      assign keep_mask[gi] = ({1'b0, count_after} + EXT_W'(gi)) >= EXT_W'(BUF_W);
    end
  endgenerate

  assign buf_next   = accepted ? ((shifted & keep_mask) | word_ext) : shifted;
  assign count_next = accepted ? (count_after + CNT_W'(WIDTH)) : count_after;

  // Right-justify the top len bits; a shift of MAX_LEN yields zero for len = 0.
  assign field_next = buf_reg[BUF_W-1 -: MAX_LEN] >> (LEN_W'(MAX_LEN) - len);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_reg         <= '0;
      count_reg       <= '0;
      field_reg       <= '0;
      field_valid_reg <= 1'b0;
    end else if (bus.i_flush) begin
      count_reg       <= '0;
      field_valid_reg <= 1'b0;
    end else begin
      buf_reg         <= buf_next;
      count_reg       <= count_next;
      field_valid_reg <= served;
      if (served) begin
        field_reg <= field_next;
      end
    end
  end

  assign bus.o_word_ready  = word_ready;
  assign bus.o_req_ready   = req_ready;
  assign bus.o_field       = field_reg;
  assign bus.o_field_valid = field_valid_reg;
  assign bus.o_count       = count_reg;
endmodule

// File: tb/tb_word_unpacker.sv
// Self-checking bench for word_unpacker: a bit-queue model predicts fields into a scoreboard
// that a monitor drains whenever the unpacker presents a field.
module tb_word_unpacker;
  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  word_unpacker_if bus ();

  word_unpacker dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  localparam logic [127:0] W1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] WA = {32{4'hA}};
  localparam logic [127:0] WF = {128{1'b1}};

  int          checks = 0;
  int          errors = 0;
  bit          model_q[$];
  logic [31:0] exp_q[$];
  logic        pend_valid = 1'b0;
  logic        pend_rst   = 1'b0;
  logic        mon_en     = 1'b0;
  logic [31:0] hold_field = 32'h0;
  logic [31:0] mon_ef;
  logic        obs_wr;
  logic        obs_rr;

  // Drive one cycle of stimulus, advance the bit-queue model and queue the predicted field.
  task automatic drive(input logic rst, input logic flush, input logic wv,
                       input logic [127:0] w, input logic rv, input int len);
    int          eff;
    bit          srv;
    bit          acc;
    logic [31:0] f;
    i_reset          = rst;
    bus.i_flush      = flush;
    bus.i_word_valid = wv;
    bus.i_word       = w;
    bus.i_req_valid  = rv;
    bus.i_req_len    = 6'(len);
    #1;
    obs_wr     = bus.o_word_ready;
    obs_rr     = bus.o_req_ready;
    pend_valid = 1'b0;
    pend_rst   = rst;
    if (rst || flush) begin
      model_q.delete();
    end else begin
      eff = (len > 32) ? 32 : len;
      srv = rv && (model_q.size() >= eff);
      acc = wv && (model_q.size() <= 128);
      if (srv) begin
        f = 32'h0;
        for (int i = 0; i < eff; i++) f = {f[30:0], model_q.pop_front()};
        exp_q.push_back(f);
        pend_valid = 1'b1;
      end
      if (acc) begin
        for (int i = 127; i >= 0; i--) model_q.push_back(w[i]);
      end
    end
    @(posedge i_clk);
    #3;
    pend_rst         = 1'b0;
    pend_valid       = 1'b0;
    i_reset          = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_word_valid = 1'b0;
    bus.i_req_valid  = 1'b0;
    bus.i_req_len    = 6'd0;
  endtask

  // Scoreboard monitor: every cycle, valid/field/count against the model.
  always @(posedge i_clk) begin
    #2;
    if (mon_en) begin
      if (pend_rst) hold_field = 32'h0;
      checks++;
      if (bus.o_field_valid !== pend_valid) begin
        errors++;
        $display("FAIL field_valid: got %b expected %b at %0t", bus.o_field_valid, pend_valid, $time);
      end
      if (pend_valid && exp_q.size() > 0) begin
        mon_ef     = exp_q.pop_front();
        hold_field = mon_ef;
        $display("field %08h count %0d", bus.o_field, bus.o_count);
      end
      checks++;
      if (bus.o_field !== hold_field) begin
        errors++;
        $display("FAIL field_value: got %08h expected %08h at %0t", bus.o_field, hold_field, $time);
      end
      checks++;
      if (bus.o_count !== 9'(model_q.size())) begin
        errors++;
        $display("FAIL count_model: got %0d expected %0d at %0t", bus.o_count, model_q.size(), $time);
      end
    end
  end

  task automatic test_reset();
    mon_en = 1'b1;
    drive(1, 0, 0, '0, 0, 0);
    drive(1, 0, 0, '0, 0, 0);
    checks++;
    if (bus.o_count !== 9'd0 || bus.o_field !== 32'h0 || bus.o_field_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count %0d field %08h valid %b, expected 0/0/0", bus.o_count, bus.o_field, bus.o_field_valid);
    end
    bus.i_req_len = 6'd1;
    #1;
    checks++;
    if (bus.o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_ready_len1: got %b expected 0", bus.o_req_ready);
    end
    bus.i_req_len = 6'd0;
    #1;
    checks++;
    if (bus.o_req_ready !== 1'b1 || bus.o_word_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_len0: req %b word %b expected 1/1", bus.o_req_ready, bus.o_word_ready);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_f [3] = '{32'h01, 32'h2345, 32'h6};
    int          lens  [3] = '{8, 16, 4};
    drive(0, 1, 0, '0, 0, 0);
    drive(0, 0, 1, W1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, '0, 1, lens[i]);
      checks++;
      if (bus.o_field !== exp_f[i] || bus.o_field_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_field%0d: got %08h valid %b expected %08h", i, bus.o_field, bus.o_field_valid, exp_f[i]);
      end
    end
    checks++;
    if (bus.o_count !== 9'd100) begin
      errors++;
      $display("FAIL seq_count: got %0d expected 100", bus.o_count);
    end
  endtask

  task automatic test_straddle();
    drive(0, 1, 0, '0, 0, 0);
    drive(0, 0, 1, WF, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, '0, 1, 32);
    drive(0, 0, 0, '0, 1, 24);
    drive(0, 0, 1, WA, 0, 0);
    drive(0, 0, 0, '0, 1, 32);
    checks++;
    if (bus.o_field !== 32'hFFAA_AAAA || bus.o_count !== 9'd104) begin
      errors++;
      $display("FAIL straddle: field %08h count %0d expected ffaaaaaa/104", bus.o_field, bus.o_count);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] x1, x2, x3;
    x1 = {$urandom, $urandom, $urandom, $urandom};
    x2 = {$urandom, $urandom, $urandom, $urandom};
    x3 = {$urandom, $urandom, $urandom, $urandom};
    drive(0, 1, 0, '0, 0, 0);
    drive(0, 0, 1, x1, 0, 0);
    drive(0, 0, 1, x2, 0, 0);
    checks++;
    if (bus.o_count !== 9'd256) begin
      errors++;
      $display("FAIL bp_full_count: got %0d expected 256", bus.o_count);
    end
    drive(0, 0, 1, x3, 0, 0);
    checks++;
    if (obs_wr !== 1'b0 || bus.o_count !== 9'd256) begin
      errors++;
      $display("FAIL bp_hold: word_ready %b count %0d expected 0/256", obs_wr, bus.o_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, x3, 1, 32);
      checks++;
      if (obs_wr !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready_drain%0d: got %b expected 0", i, obs_wr);
      end
    end
    drive(0, 0, 1, x3, 1, 32);
    checks++;
    if (obs_wr !== 1'b1 || bus.o_count !== 9'd224) begin
      errors++;
      $display("FAIL bp_accept: word_ready %b count %0d expected 1/224", obs_wr, bus.o_count);
    end
    for (int i = 0; i < 7; i++) drive(0, 0, 0, '0, 1, 32);
    checks++;
    if (bus.o_count !== 9'd0) begin
      errors++;
      $display("FAIL bp_empty: got %0d expected 0", bus.o_count);
    end
  endtask

  task automatic test_simultaneous();
    drive(0, 1, 0, '0, 0, 0);
    drive(0, 0, 1, W1, 0, 0);
    drive(0, 0, 0, '0, 1, 28);
    drive(0, 0, 1, WA, 1, 32);
    checks++;
    if (obs_wr !== 1'b1 || obs_rr !== 1'b1 || bus.o_count !== 9'd196 || bus.o_field !== 32'h789A_BCDE) begin
      errors++;
      $display("FAIL simul_both: wr %b rr %b count %0d field %08h expected 1/1/196/789abcde", obs_wr, obs_rr, bus.o_count, bus.o_field);
    end
    drive(0, 1, 0, '0, 0, 0);
    drive(0, 0, 1, W1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, '0, 1, 32);
    drive(0, 0, 0, '0, 1, 12);
    drive(0, 0, 1, WA, 1, 32);
    checks++;
    if (obs_wr !== 1'b1 || obs_rr !== 1'b0 || bus.o_field_valid !== 1'b0 || bus.o_count !== 9'd148) begin
      errors++;
      $display("FAIL simul_stall: wr %b rr %b valid %b count %0d expected 1/0/0/148", obs_wr, obs_rr, bus.o_field_valid, bus.o_count);
    end
    drive(0, 0, 0, '0, 1, 32);
    checks++;
    if (obs_rr !== 1'b1 || bus.o_field !== 32'h4321_0AAA || bus.o_count !== 9'd116) begin
      errors++;
      $display("FAIL simul_retry: rr %b field %08h count %0d expected 1/43210aaa/116", obs_rr, bus.o_field, bus.o_count);
    end
  endtask

  task automatic test_flush_sat_reset();
    logic [31:0] prev;
    drive(0, 1, 0, '0, 0, 0);
    drive(0, 0, 1, W1, 0, 0);
    drive(0, 0, 0, '0, 1, 32);
    drive(0, 0, 0, '0, 1, 19);
    prev = bus.o_field;
    checks++;
    if (bus.o_count !== 9'd77) begin
      errors++;
      $display("FAIL flush_pre_count: got %0d expected 77", bus.o_count);
    end
    drive(0, 1, 1, WA, 1, 8);
    checks++;
    if (obs_wr !== 1'b0 || obs_rr !== 1'b0 || bus.o_count !== 9'd0 || bus.o_field_valid !== 1'b0 || bus.o_field !== prev) begin
      errors++;
      $display("FAIL flush: wr %b rr %b count %0d valid %b field %08h expected 0/0/0/0/%08h", obs_wr, obs_rr, bus.o_count, bus.o_field_valid, bus.o_field, prev);
    end
    drive(0, 0, 1, W1, 0, 0);
    drive(0, 0, 0, '0, 1, 40);
    checks++;
    if (bus.o_field !== 32'h0123_4567 || bus.o_count !== 9'd96) begin
      errors++;
      $display("FAIL saturate: field %08h count %0d expected 01234567/96", bus.o_field, bus.o_count);
    end
    drive(0, 0, 0, '0, 1, 0);
    checks++;
    if (bus.o_field_valid !== 1'b1 || bus.o_field !== 32'h0 || bus.o_count !== 9'd96) begin
      errors++;
      $display("FAIL len_zero: valid %b field %08h count %0d expected 1/0/96", bus.o_field_valid, bus.o_field, bus.o_count);
    end
    drive(0, 0, 0, '0, 1, 8);
    drive(1, 0, 0, '0, 0, 0);
    checks++;
    if (bus.o_field_valid !== 1'b0 || bus.o_count !== 9'd0 || bus.o_field !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: valid %b count %0d field %08h expected 0/0/0", bus.o_field_valid, bus.o_count, bus.o_field);
    end
    drive(0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    i_reset          = 1'b1;
    bus.i_flush      = 1'b0;
    bus.i_word_valid = 1'b0;
    bus.i_word       = '0;
    bus.i_req_valid  = 1'b0;
    bus.i_req_len    = 6'd0;
    test_reset();
    test_sequential();
    test_straddle();
    test_backpressure();
    test_simultaneous();
    test_flush_sat_reset();
    drive(0, 0, 0, '0, 0, 0);
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d fields never observed, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
